nv_csa_tree_pipe: RTL
=====================

Name: nv_csa_tree_pipe

Overview:
Parametrised, pipelined carry-save (3:2) reduction tree. It compresses NUM_INPUTS operands of WIDTH bits into two redundant outputs, OUT0 and OUT1, with OUT0+OUT1 = sum of inputs mod 2^WIDTH. It succeeds the combinational DW02-style tree and adds three things: pipeline registers every LEVELS_PER_STAGE CSA levels, valid/ready flow control with per-stage stall and bubble collapse, and an optional final carry-propagate adder. It sits in the MAC datapath between partial-product generation and the accumulator.

Parameters:
NUM_INPUTS, 5, number of operands; must be >= 2.
WIDTH, 24, operand and output bit-width.
LEVELS_PER_STAGE, 2, CSA levels between pipeline registers; must be >= 1.

Ports:
nvdla_core_clk  input  1  core clock; all state samples on the rising edge.
nvdla_core_rstn  input  1  asynchronous, active-low reset.
in_pvld  input  1  input operand bundle valid.
in_prdy  output  1  block can accept an input bundle.
in_pd  input  NUM_INPUTS*WIDTH  operand i occupies bits [i*WIDTH +: WIDTH].
out_pvld  output  1  result valid.
out_prdy  input  1  downstream accepts the result.
out0_pd  output  WIDTH  redundant sum word.
out1_pd  output  WIDTH  redundant carry word.

Behaviour:
- Level count L: apply n -> n - floor(n/3), starting at n = NUM_INPUTS, until n <= 2; L is the number of iterations. Defaults: 5->4->3->2, so L = 3.
- Each level operates on the current array of n words:
  - Groups in order: words (3k, 3k+1, 3k+2) -> sum = a^b^c; carry = maj(a,b,c)<<1, with the MSB dropped.
  - New array order is sum0, carry0, sum1, carry1, ..., then the n%3 leftover words passed through in order.
  - Output is bit-exact to this grouping, not merely sum-equivalent.
- Pipeline structure:
  - Number of stages S = max(1, ceil(L/LPS)).
  - Stage s holds the result after min((s+1)*LPS, L) levels. The last stage drives out0_pd = word0 and out1_pd = word1.
  - L = 0 (NUM_INPUTS = 2): single register stage, pass-through.
- Latency: S cycles from an accepted input to out_pvld with out_prdy held high (defaults: S = 2).
- Flow control, per stage valid bit v[s]:
  - Stage s loads when !v[s] or stage s is draining. Stage S-1 drains when out_prdy. Stage s < S-1 drains when stage s+1 loads.
  - in_prdy = stage 0 load enable; combinational from out_prdy through the chain.
  - On load, v[s] takes upstream valid; empty stages fill (bubbles collapse).
  - A stalled stage holds its data and valid.
- Throughput is 1 result per cycle with out_prdy high. Capacity is S bundles; with out_prdy low, in_prdy drops once all S stages are valid.
- Data registers load only when the upstream stage is valid; no toggling on bubbles.
- Reset (async assert, sync deassert externally):
  - All v[s] = 0 and all data registers = 0, so out_pvld = 0, out0_pd = out1_pd = 0.
  - in_prdy = 1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight bundle; no partial output appears.
- Simultaneous drain and load of a full pipeline: the stage takes new data in the same cycle; no bubble is inserted.

Optional Feature:
NV_CSA_TREE_FINAL_ADD_EN
- Defined:
  - One extra register stage after the tree computes word0 + word1 mod 2^WIDTH.
  - out0_pd = full sum; out1_pd = 0.
  - Latency and capacity become S+1.
- Undefined: redundant outputs as above.
- Handshake rules are identical in both builds.

Decomposition:
- Shared package/include nv_csa_tree_pkg:
  - Function csa_num_levels(n).
  - Function csa_words_after(n, lvl).
  - Function csa_num_stages(n, lps).
  - Localparam helpers.
- Sub-module nv_csa_level: one combinational 3:2 level, parametrised by NUM_IN and WIDTH, producing csa_words_after(NUM_IN,1) words. Instantiated L times via generate.
- Stage valid/enable logic stays in the top module.

Test Plan:
- Defaults, in_pd = {5,4,3,2,1}, out_prdy = 1: out_pvld rises 2 cycles after acceptance; out0+out1 = 15. Also check bit-exact match to the reference grouping model.
- All five operands 0xFFFFFF: out0+out1 mod 2^24 = 0xFFFFFB, with carry MSB drops verified.
- out_prdy = 0 with 3 back-to-back valid inputs: 2 are accepted and in_prdy = 0 on the third. Raise out_prdy: outputs appear in order, one per cycle, with no loss or duplication.
- Random in_pvld/out_prdy over 10k bundles with NUM_INPUTS in {2,3,7,16} and LPS in {1,3}: scoreboard order and sums. For NUM_INPUTS = 2, latency = 1 and the output equals the input.
- Assert nvdla_core_rstn low while 2 bundles are in flight: out_pvld = 0 and outputs 0 immediately; in_prdy = 1 after release; no stale outputs.
- With NV_CSA_TREE_FINAL_ADD_EN, {5,4,3,2,1}: out0_pd = 15, out1_pd = 0, latency 3.

Source files
------------

// File: rtl/nv_csa_tree_pkg.sv
// Shared helpers for the pipelined carry-save reduction tree: level/word/stage counts.
package nv_csa_tree_pkg;

  localparam int unsigned CSA_MIN_INPUTS = 2;
  localparam int unsigned CSA_MIN_WIDTH  = 2;

  // Words remaining after lvl 3:2 levels applied to n words.
  function automatic int unsigned csa_words_after(int unsigned n, int unsigned lvl);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      if (w > 2) w = w - w / 3;
    end
    return w;
  endfunction

  function automatic int unsigned csa_num_levels(int unsigned n);
    int unsigned w;
    int unsigned l;
    w = n;
    l = 0;
    while (w > 2) begin
      w = w - w / 3;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic int unsigned csa_num_stages(int unsigned n, int unsigned lps);
    int unsigned l;
    l = csa_num_levels(n);
    return (l == 0) ? 1 : (l + lps - 1) / lps;
  endfunction

  // Total levels completed once stage s has been loaded.
  function automatic int unsigned csa_stage_last_level(int unsigned n, int unsigned lps,
                                                       int unsigned s);
    int unsigned l;
    l = csa_num_levels(n);
    return ((s + 1) * lps > l) ? l : (s + 1) * lps;
  endfunction

endpackage

// File: rtl/nv_csa_level.sv
// One combinational 3:2 compression level: groups (3k,3k+1,3k+2) -> sum, carry; leftovers pass.
module nv_csa_level
  import nv_csa_tree_pkg::*;
#(
  parameter  int unsigned NUM_IN  = 3,
  parameter  int unsigned WIDTH   = 24,
  localparam int unsigned NUM_OUT = csa_words_after(NUM_IN, 1)
) (
  input  logic [NUM_IN*WIDTH-1:0]  words,
  output logic [NUM_OUT*WIDTH-1:0] reduced
);

  localparam int unsigned GROUPS = NUM_IN / 3;
  localparam int unsigned REM    = NUM_IN % 3;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [WIDTH-1:0] a, b, c;
    logic [WIDTH-2:0] maj;
    assign a = words[(3*g)*WIDTH +: WIDTH];
    assign b = words[(3*g+1)*WIDTH +: WIDTH];
    assign c = words[(3*g+2)*WIDTH +: WIDTH];
    // Carry MSB falls off the word, so only the low WIDTH-1 majority bits matter.
    assign maj = (a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                 (b[WIDTH-2:0] & c[WIDTH-2:0]);
    assign reduced[(2*g)*WIDTH +: WIDTH]   = a ^ b ^ c;
    assign reduced[(2*g+1)*WIDTH +: WIDTH] = {maj, 1'b0};
  end

  for (genvar r = 0; r < REM; r++) begin : g_rem
    assign reduced[(2*GROUPS+r)*WIDTH +: WIDTH] = words[(3*GROUPS+r)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/nv_csa_tree_pipe.sv
// Pipelined carry-save reduction tree with valid/ready flow control per stage.
// Define NV_CSA_TREE_FINAL_ADD_EN to append a carry-propagate stage (out0 = sum, out1 = 0).
module nv_csa_tree_pipe
  import nv_csa_tree_pkg::*;
#(
  parameter int unsigned NUM_INPUTS       = 5,
  parameter int unsigned WIDTH            = 24,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        in_pvld,
  output logic                        in_prdy,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_pd,
  output logic                        out_pvld,
  input  logic                        out_prdy,
  output logic [WIDTH-1:0]            out0_pd,
  output logic [WIDTH-1:0]            out1_pd
);

  localparam int unsigned S = csa_num_stages(NUM_INPUTS, LEVELS_PER_STAGE);
`ifdef NV_CSA_TREE_FINAL_ADD_EN
  localparam int unsigned NSTG = S + 1;
`else
  localparam int unsigned NSTG = S;
`endif

  logic [NSTG-1:0] v;
  logic [NSTG-1:0] ld;
  logic [NSTG-1:0] up_v;

  // Load enables ripple back from the output: a stage loads if empty or its successor takes it.
  always_comb begin
    ld = '0;
    ld[NSTG-1] = ~v[NSTG-1] | out_prdy;
    for (int s = int'(NSTG) - 2; s >= 0; s--) begin
      ld[s] = ~v[s] | ld[s+1];
    end
  end

  assign up_v     = NSTG'({v, in_pvld});
  assign in_prdy  = ld[0];
  assign out_pvld = v[NSTG-1];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      v <= '0;
    end else begin
      for (int s = 0; s < int'(NSTG); s++) begin
        if (ld[s]) v[s] <= up_v[s];
      end
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_stg
    localparam int unsigned LV_LO = (s == 0) ? 0 :
        csa_stage_last_level(NUM_INPUTS, LEVELS_PER_STAGE, s - 1);
    localparam int unsigned LV_HI = csa_stage_last_level(NUM_INPUTS, LEVELS_PER_STAGE, s);
    localparam int unsigned NL    = LV_HI - LV_LO;
    localparam int unsigned NIN   = csa_words_after(NUM_INPUTS, LV_LO);
    localparam int unsigned NQ    = csa_words_after(NUM_INPUTS, LV_HI);

    logic [NIN*WIDTH-1:0] d_in;
    logic [NQ*WIDTH-1:0]  d_nxt;
    logic [NQ*WIDTH-1:0]  q;

    if (s == 0) begin : g_src_in
      assign d_in = in_pd;
    end else begin : g_src_stg
      assign d_in = g_stg[s-1].q;
    end

    if (NL == 0) begin : g_pass
      assign d_nxt = d_in;
    end else begin : g_chain
      for (genvar k = 0; k < NL; k++) begin : g_lv
        localparam int unsigned KI = csa_words_after(NUM_INPUTS, LV_LO + k);
        localparam int unsigned KO = csa_words_after(NUM_INPUTS, LV_LO + k + 1);
        logic [KI*WIDTH-1:0] a;
        logic [KO*WIDTH-1:0] y;
        if (k == 0) begin : g_first
          assign a = d_in;
        end else begin : g_next
          assign a = g_lv[k-1].y;
        end
        nv_csa_level #(.NUM_IN(KI), .WIDTH(WIDTH)) u_lvl (.words(a), .reduced(y));
      end
      assign d_nxt = g_lv[NL-1].y;
    end

    // Data only moves when real data arrives, so bubbles do not toggle the registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
        q <= '0;
      end else if (ld[s] && up_v[s]) begin
        q <= d_nxt;
      end
    end
  end

  logic [2*WIDTH-1:0] tree_q;
  assign tree_q = g_stg[S-1].q;

`ifdef NV_CSA_TREE_FINAL_ADD_EN
  logic [WIDTH-1:0] fsum;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      fsum <= '0;
    end else if (ld[S] && up_v[S]) begin
      fsum <= tree_q[WIDTH-1:0] + tree_q[2*WIDTH-1:WIDTH];
    end
  end

  assign out0_pd = fsum;
  assign out1_pd = '0;
`else
  assign out0_pd = tree_q[WIDTH-1:0];
  assign out1_pd = tree_q[2*WIDTH-1:WIDTH];
`endif

endmodule
